multiword_add_ctrl: RTL
=======================

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 SHALL have parameter N, default 32: width of the external combinational adder slice, a multiple of 4.
REQ-002 SHALL have parameter WORDS, default 2: words per operand, range 2..8; the full operand width W = N*WORDS.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, W), in_b (input, W) and in_cin (input, 1): operand request.
REQ-006 SHALL have port in_sub, input, 1: subtract request; present only with MWADD_SUB_EN.
REQ-007 SHALL have ports add_a (output, N), add_b (output, N) and add_cin (output, 1): drive to the adder slice.
REQ-008 SHALL have ports add_sum (input, N), add_cout (input, 1) and add_ovf (input, 1): results returned by the adder slice in the same cycle.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_sum (output, W), out_cout (output, 1) and out_ovf (output, 1): result.

Function
REQ-010 SHALL implement three states, IDLE, RUN and DONE, held in a registered state variable.
REQ-011 SHALL hold in_ready=1 only in IDLE; an in_valid&in_ready cycle captures in_a, in_b, in_cin (and in_sub) into registers, clears word index idx to 0 and moves to RUN.
REQ-012 SHALL, in RUN, drive add_a and add_b with word idx of the captured operands; add_cin is the captured cin when idx=0, otherwise the registered carry of the previous word.
REQ-013 SHALL, in each RUN cycle, write add_sum into out_sum word idx, register add_cout as the next carry, and increment idx.
REQ-014 SHALL, when idx=WORDS-1 in RUN, register out_cout=add_cout and out_ovf=add_ovf, then move to DONE.
REQ-015 SHALL have a latency from the accepting cycle to out_valid=1 of exactly WORDS+1 cycles; throughput SHALL be one operation per WORDS+2 cycles when out_ready=1.
REQ-016 SHALL assert out_valid only in DONE; out_sum, out_cout and out_ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, in DONE with out_ready=1, move to IDLE; a new request SHALL not be accepted in that same cycle (in_ready=0 in DONE).
REQ-018 SHALL ignore in_valid and in_a/in_b changes outside IDLE; captured operands are immutable until DONE exits.
REQ-019 SHALL drive add_a, add_b and add_cin to 0 in IDLE and DONE.
REQ-020 SHALL treat out_cout as the carry out of the top word and out_ovf as the signed overflow of the full W-bit operation; all arithmetic wraps modulo 2^W.

Reset
REQ-021 SHALL, on rst_n low at any time (including mid-RUN), force IDLE, idx=0, carry=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0 and in_ready=0 while reset is held.
REQ-022 SHALL set in_ready=1 in the first cycle after rst_n deasserts; an in-flight operation is discarded with no output.

Configuration
REQ-023 SHALL, with MWADD_SUB_EN defined, add port in_sub; when the captured in_sub=1, add_b drives the bitwise inverse of word idx of b and add_cin at idx=0 drives 1 (in_cin ignored), giving a-b.
REQ-024 SHALL, without MWADD_SUB_EN, have no in_sub port and perform addition only.

Structure
REQ-025 SHALL place the state enumeration (IDLE/RUN/DONE encodings) and the default N/WORDS constants in a shared package, mwadd_pkg.
REQ-026 SHALL keep the adder slice external; the block contains no sub-module and is only the sequencer and datapath registers.

Verification
REQ-027 SHALL cover, with N=32, WORDS=2 and a behavioural slice: a=0x00000000_FFFFFFFF, b=1, cin=0 -> sum=0x00000001_00000000, cout=0, ovf=0, out_valid on cycle 3 after accept.
REQ-028 SHALL cover: a=b=0xFFFFFFFF_FFFFFFFF, cin=1 -> sum=0xFFFFFFFF_FFFFFFFF, cout=1, ovf=0.
REQ-029 SHALL cover: a=0x7FFFFFFF_FFFFFFFF, b=1 -> sum=0x80000000_00000000, ovf=1, cout=0.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout; accept resumes the cycle after the handshake.
REQ-031 SHALL cover: rst_n pulsed low during RUN idx=1 -> out_valid never asserts and all outputs 0; the next request completes correctly.
REQ-032 SHALL cover, with MWADD_SUB_EN: a=0, b=1, in_sub=1 -> sum=0xFFFFFFFF_FFFFFFFF, cout=0.

Source files
------------

// File: rtl/mwadd_pkg.sv
// Shared definitions for the multiword add sequencer.
//   mwadd_state_t : sequencer state encoding (IDLE / RUN / DONE)
//   MWADD_N       : default width of the external adder slice
//   MWADD_WORDS   : default number of slice-wide words per operand
package mwadd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mwadd_state_t;

    localparam int MWADD_N     = 32;
    localparam int MWADD_WORDS = 2;

endpackage

// File: rtl/multiword_add_ctrl.sv
// Multiword add sequencer: walks a W = N*WORDS bit addition through an
// external N-bit combinational adder slice, one word per cycle, least
// significant word first, chaining the carry through a register.
//
// Optional feature: define MWADD_SUB_EN to add the in_sub port; a captured
// in_sub=1 feeds the slice with ~b and a forced carry-in of 1, giving a-b.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin          : W-bit operands and carry-in
//   in_sub                      : subtract request (MWADD_SUB_EN only)
//   add_a, add_b, add_cin       : word operands driven to the adder slice
//   add_sum, add_cout, add_ovf  : same-cycle results from the adder slice
//   out_valid/out_ready         : result handshake (valid only in DONE)
//   out_sum, out_cout, out_ovf  : W-bit sum, top carry, signed overflow
module multiword_add_ctrl
    import mwadd_pkg::*;
#(
    parameter int N     = MWADD_N,
    parameter int WORDS = MWADD_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_cin,
`ifdef MWADD_SUB_EN
    input  logic               in_sub,
`endif
    output logic [N-1:0]       add_a,
    output logic [N-1:0]       add_b,
    output logic               add_cin,
    input  logic [N-1:0]       add_sum,
    input  logic               add_cout,
    input  logic               add_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               out_ovf
);

    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    mwadd_state_t     state, state_nxt;
    logic [W-1:0]     a_q, b_q;
    logic             cin_q;
    logic             sub_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [W-1:0]     sum_q;
    logic             cout_q, ovf_q;

    logic             accept;
    logic             last_word;
    logic [N-1:0]     a_word, b_word;
    logic             first_cin;

    assign accept    = in_valid && in_ready;
    assign last_word = (idx == IDX_W'(WORDS - 1));
    assign a_word    = a_q[int'(idx)*N +: N];
    assign b_word    = b_q[int'(idx)*N +: N];

    // Subtraction is a + ~b + 1, so the first word's carry-in is forced high.
    assign first_cin = sub_q ? 1'b1 : cin_q;

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            ST_IDLE: begin
                // State is already IDLE while reset is held; gating with
                // rst_n keeps the handshake closed until reset releases.
                in_ready = rst_n;
                if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                add_a   = a_word;
                add_b   = sub_q ? ~b_word : b_word;
                add_cin = (idx == '0) ? first_cin : carry_q;
                if (last_word) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            idx     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            cin_q   <= in_cin;
            idx     <= '0;
            carry_q <= 1'b0;
        end else if (state == ST_RUN) begin
            sum_q[int'(idx)*N +: N] <= add_sum;
            carry_q                 <= add_cout;
            if (last_word) begin
                idx    <= '0;
                cout_q <= add_cout;
                ovf_q  <= add_ovf;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef MWADD_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= in_sub;
        end
    end
`else
    assign sub_q = 1'b0;
`endif

endmodule
